// File: rtl/llm_pkg.sv
// -----------------------------------------------------------------------------
// llm_pkg
// Shared types and default sizing for the outlier scatter/gather datapath.
//   IN_WIDTH        element width in bits (FP16 payload)
//   IN_SIZE         elements per row
//   IN_PARALLELISM  rows per tile
//   IND_FIFO_DEPTH  indicator tiles buffered between scatter and gather
// Types:
//   ind_tile_t  one indicator bit per element (1 = large path, 0 = small path)
//   elem_t      one data element
// -----------------------------------------------------------------------------
package llm_pkg;

    localparam int IN_WIDTH       = 16;
    localparam int IN_SIZE        = 4;
    localparam int IN_PARALLELISM = 1;
    localparam int IND_FIFO_DEPTH = 4;
    localparam int TILE_ELEMS     = IN_SIZE * IN_PARALLELISM;

    typedef logic [TILE_ELEMS-1:0] ind_tile_t;
    typedef logic [IN_WIDTH-1:0]   elem_t;

endpackage

// File: rtl/ind_fifo.sv
// -----------------------------------------------------------------------------
// ind_fifo
// Synchronous FIFO holding indicator tiles until the matching result tiles
// arrive. Storage is a plain register array read combinationally at the head,
// so an entry written at an edge becomes visible at the head only after that
// edge (no write-to-read bypass).
// Ports:
//   clk, rst            clock, asynchronous active-low reset
//   push, push_data     write request / tile (ignored while full)
//   pop                 remove head entry (ignored while empty)
//   pop_data            current head entry
//   count               entries stored, 0..DEPTH
//   full, empty         status flags derived from count
// DEPTH must be a power of two >= 2 so the pointers wrap by overflow.
// -----------------------------------------------------------------------------
module ind_fifo
    import llm_pkg::*;
#(
    parameter int WIDTH = $bits(ind_tile_t),
    parameter int DEPTH = IND_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CW'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Payload storage needs no reset: the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/gather.sv
// -----------------------------------------------------------------------------
// gather
// Re-merges the large-path and small-path result tiles into one dense tile,
// choosing per element with the indicator tile recorded at scatter time.
// Optional checker: define GATHER_CHECK_EN to flag non-zero elements on the
// deselected path (sticky merge_err); otherwise merge_err is tied to 0.
// Ports:
//   clk, rst                                  clock, async active-low reset
//   ind_in / _valid / _ready                  indicator tile stream (queued)
//   data_in_large / _valid / _ready           large-path result tile stream
//   data_in_small / _valid / _ready           small-path result tile stream
//   data_out / _valid / _ready                merged tile, registered
//   ind_count                                 indicator tiles queued
//   merge_err                                 sticky deselected-path error
//
// Handshake: a transfer happens on a stream in a cycle where both its valid
// and ready are high at the clock edge. Valid never waits on ready; the two
// result streams share one ready that rises only when the indicator head, both
// result tiles and room in the output register are all present, so the three
// inputs are consumed together in a single edge.
// -----------------------------------------------------------------------------
module gather
    import llm_pkg::*;
#(
    parameter int IN_WIDTH       = llm_pkg::IN_WIDTH,
    parameter int IN_SIZE        = llm_pkg::IN_SIZE,
    parameter int IN_PARALLELISM = llm_pkg::IN_PARALLELISM,
    parameter int IND_FIFO_DEPTH = llm_pkg::IND_FIFO_DEPTH
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic [IN_SIZE*IN_PARALLELISM-1:0]             ind_in,
    input  logic                                          ind_in_valid,
    output logic                                          ind_in_ready,
    input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in_large,
    input  logic                                          data_in_large_valid,
    output logic                                          data_in_large_ready,
    input  logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_in_small,
    input  logic                                          data_in_small_valid,
    output logic                                          data_in_small_ready,
    output logic [IN_SIZE*IN_PARALLELISM-1:0][IN_WIDTH-1:0] data_out,
    output logic                                          data_out_valid,
    input  logic                                          data_out_ready,
    output logic [$clog2(IND_FIFO_DEPTH):0]               ind_count,
    output logic                                          merge_err
);

    localparam int N = IN_SIZE * IN_PARALLELISM;

    logic [N-1:0]               ind_head;
    logic                       fifo_full;
    logic                       fifo_empty;
    logic                       fire;
    logic [N-1:0][IN_WIDTH-1:0] merged;

    ind_fifo #(
        .WIDTH (N),
        .DEPTH (IND_FIFO_DEPTH)
    ) u_ind_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (ind_in_valid),
        .push_data (ind_in),
        .pop       (fire),
        .pop_data  (ind_head),
        .count     (ind_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready is based on the stored count only, so a pop in the same cycle
    // does not open a slot for the incoming indicator.
    assign ind_in_ready = !fifo_full;

    assign fire = !fifo_empty && data_in_large_valid && data_in_small_valid &&
                  (!data_out_valid || data_out_ready);

    assign data_in_large_ready = fire;
    assign data_in_small_ready = fire;

    always_comb begin
        merged = '0;
        for (int k = 0; k < N; k++) begin
            merged[k] = ind_head[k] ? data_in_large[k] : data_in_small[k];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out       <= '0;
            data_out_valid <= 1'b0;
        end else if (fire) begin
            data_out       <= merged;
            data_out_valid <= 1'b1;
        end else if (data_out_ready) begin
            data_out_valid <= 1'b0;
        end
    end

`ifdef GATHER_CHECK_EN
    logic path_leak;

    // An element the indicator discards should have been zeroed upstream.
    always_comb begin
        path_leak = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (ind_head[k] ? (data_in_small[k] != '0) : (data_in_large[k] != '0)) begin
                path_leak = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            merge_err <= 1'b0;
        end else if (fire && path_leak) begin
            merge_err <= 1'b1;
        end
    end
`else
    assign merge_err = 1'b0;
`endif

endmodule
